// File: rtl/vis_pkg.sv
// Shared visualiser definitions: spectrum-set defaults and the bin scheduler state type,
// also used by the VGA bar-drawing logic.
package vis_pkg;

  localparam int NUM_BINS_DEF    = 16;
  localparam int BIN_W_DEF       = 16;
  localparam int DECAY_SHIFT_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_COLLECT,
    ST_PENDING,
    ST_SWAP
  } sched_state_t;

endpackage

// File: rtl/bin_bank.sv
// Double-buffered bin register file: writes land in the hidden bank, the display bank feeds
// the registered bar read port. Peak-hold read port exists only with BIN_PEAK_HOLD_EN.
module bin_bank
  import vis_pkg::*;
#(
  parameter int NUM_BINS = NUM_BINS_DEF,
  parameter int BIN_W    = BIN_W_DEF,
  localparam int AW      = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             swap_i,
  input  logic             wr_en_i,
  input  logic [AW-1:0]    wr_addr_i,
  input  logic [BIN_W-1:0] wr_data_i,
  input  logic [AW-1:0]    rd_addr_i,
  output logic [BIN_W-1:0] rd_data_o,
`ifdef BIN_PEAK_HOLD_EN
  input  logic [AW-1:0]    ph_addr_i,
  output logic [BIN_W-1:0] ph_data_o,
`endif
  output logic             bank_sel_o
);

  logic             bank_sel_q;
  logic [BIN_W-1:0] mem_q [2][NUM_BINS];
  logic [BIN_W-1:0] rd_data_q;
  logic             rd_sel;

  // Read through the bank that will be displayed after this edge, so the bar data
  // follows the swap without a one-cycle stale value.
  assign rd_sel = bank_sel_q ^ swap_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      bank_sel_q <= 1'b0;
      rd_data_q  <= '0;
      // NOTE: the banks are flops, not RAM, so clearing them on reset is legal and keeps
      // the display blank until the first complete set arrives.
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < NUM_BINS; i++) begin
          mem_q[b][i] <= '0;
        end
      end
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (swap_i) begin
        bank_sel_q <= ~bank_sel_q;
      end
      if (wr_en_i) begin
        mem_q[~bank_sel_q][wr_addr_i] <= wr_data_i;
      end
      if (32'(rd_addr_i) < NUM_BINS) begin
        rd_data_q <= mem_q[rd_sel][rd_addr_i];
      end else begin
        rd_data_q <= '0;
      end
    end
  end

`ifdef BIN_PEAK_HOLD_EN
  assign ph_data_o = mem_q[bank_sel_q][ph_addr_i];
`endif
  assign rd_data_o  = rd_data_q;
  assign bank_sel_o = bank_sel_q;

endmodule

// File: rtl/bin_frame_scheduler.sv
// Collects spectrum sets into the hidden bank and swaps it to the display at vblank.
// Define BIN_PEAK_HOLD_EN to write max(new, decayed old) instead of the raw clamped bin.
module bin_frame_scheduler
  import vis_pkg::*;
#(
  parameter int NUM_BINS    = NUM_BINS_DEF,
  parameter int BIN_W       = BIN_W_DEF,
  parameter int DECAY_SHIFT = DECAY_SHIFT_DEF,
  localparam int AW         = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             bin_valid,
  output logic             bin_ready,
  input  logic [BIN_W-1:0] bin_data,
  input  logic             bin_last,
  input  logic             vblank_start,
  input  logic [AW-1:0]    rd_addr,
  output logic [BIN_W-1:0] rd_data,
  output logic             swap_pulse,
  output logic [7:0]       frame_err_cnt
);

  localparam logic [AW-1:0] LAST_IDX = AW'(NUM_BINS - 1);

  sched_state_t     state_q, state_d;
  logic [AW-1:0]    idx_q, idx_d;
  logic [7:0]       err_q, err_d;
  logic             wr_en;
  logic             bank_sel;
  logic [BIN_W-1:0] clamped;
  logic [BIN_W-1:0] wr_data;

  assign clamped = bin_data[BIN_W-1] ? '0 : bin_data;

`ifdef BIN_PEAK_HOLD_EN
  logic [BIN_W-1:0] old_val;
  logic [BIN_W-1:0] decayed;

  // Stored values are never negative, so a logical shift equals the arithmetic one.
  assign decayed = old_val - (old_val >> DECAY_SHIFT);
  assign wr_data = (clamped > decayed) ? clamped : decayed;
`else
  assign wr_data = clamped;
`endif

  always_comb begin
    // NOTE: defaults first so no path through the case leaves a signal unassigned (latch).
    state_d    = state_q;
    idx_d      = idx_q;
    err_d      = err_q;
    bin_ready  = 1'b0;
    swap_pulse = 1'b0;
    wr_en      = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_COLLECT: begin
        bin_ready = 1'b1;
        if (bin_valid) begin
          wr_en = 1'b1;
          if (bin_last && idx_q == LAST_IDX) begin
            state_d = ST_PENDING;
            idx_d   = '0;
          end else if (bin_last || idx_q == LAST_IDX) begin
            // Malformed set: drop it, the display bank is untouched.
            state_d = ST_IDLE;
            idx_d   = '0;
            if (err_q != 8'hFF) err_d = err_q + 8'd1;
          end else begin
            state_d = ST_COLLECT;
            idx_d   = idx_q + AW'(1);
          end
        end
      end
      ST_PENDING: begin
        if (vblank_start) state_d = ST_SWAP;
      end
      ST_SWAP: begin
        swap_pulse = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end

  bin_bank #(
    .NUM_BINS (NUM_BINS),
    .BIN_W    (BIN_W)
  ) u_bank (
    .clk        (clk),
    .rst        (rst),
    .swap_i     (swap_pulse),
    .wr_en_i    (wr_en),
    .wr_addr_i  (idx_q),
    .wr_data_i  (wr_data),
    .rd_addr_i  (rd_addr),
    .rd_data_o  (rd_data),
`ifdef BIN_PEAK_HOLD_EN
    .ph_addr_i  (idx_q),
    .ph_data_o  (old_val),
`endif
    .bank_sel_o (bank_sel)
  );

  assign frame_err_cnt = err_q;

  // Bank select is exposed for the display side; the scheduler itself does not need it.
  logic unused_bank_sel;
  assign unused_bank_sel = bank_sel;

endmodule

// File: doc/bin_frame_scheduler.md
BIN_FRAME_SCHEDULER -- requirements
Module: bin_frame_scheduler

Interface
REQ-001 SHALL have parameter NUM_BINS, default 16: bins per spectrum set (one bar each).
REQ-002 SHALL have parameter BIN_W, default 16: bin width; signed two's complement.
REQ-003 SHALL have parameter DECAY_SHIFT, default 4: peak-hold decay shift.
REQ-004 SHALL use one clock; reset is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1: pixel clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1: synchronous active-high reset.
REQ-007 SHALL have port bin_valid, input, 1: bin_data/bin_last valid.
REQ-008 SHALL have port bin_ready, output, 1: scheduler accepts the bin.
REQ-009 SHALL have port bin_data, input, BIN_W: signed bin magnitude.
REQ-010 SHALL have port bin_last, input, 1: marks the final bin of a set.
REQ-011 SHALL have port vblank_start, input, 1: one-cycle pulse at the start of vertical blanking.
REQ-012 SHALL have port rd_addr, input, $clog2(NUM_BINS): display bar index.
REQ-013 SHALL have port rd_data, output, BIN_W: display-bank value for rd_addr; registered.
REQ-014 SHALL have port swap_pulse, output, 1: one-cycle pulse when banks swap.
REQ-015 SHALL have port frame_err_cnt, output, 8: count of malformed or dropped sets; saturating.

Function
REQ-016 SHALL keep two banks of NUM_BINS x BIN_W: a write bank and a display bank; a bank select bit picks the display bank.
REQ-017 SHALL implement FSM IDLE, COLLECT, PENDING, SWAP.
REQ-018 IDLE: bin_ready=1; on the first accepted bin, SHALL write index 0 and move to COLLECT, or to PENDING if bin_last is also set and NUM_BINS=1.
REQ-019 A transfer SHALL occur only when bin_valid && bin_ready; the index counter SHALL increment per transfer.
REQ-020 COLLECT: bin_ready=1; bin_last at index NUM_BINS-1 -> PENDING.
REQ-021 bin_last at index < NUM_BINS-1, or no bin_last at NUM_BINS-1, SHALL discard the set, increment frame_err_cnt and return to IDLE. The index resets, the display bank is unchanged and the transfer is consumed.
REQ-022 Negative bin_data (MSB=1) SHALL be stored as 0.
REQ-023 PENDING: bin_ready=0; on vblank_start -> SWAP.
REQ-024 SWAP: SHALL toggle bank select, assert swap_pulse for exactly that cycle, then go to IDLE; bin_ready=0.
REQ-025 vblank_start in IDLE, COLLECT or SWAP SHALL have no effect; the display bank holds the last complete set.
REQ-026 A set accepted while in COLLECT that misses a vblank_start SHALL wait in PENDING for the next one; it is not an error.
REQ-027 rd_data SHALL equal the display-bank entry at the rd_addr sampled one cycle earlier. rd_addr >= NUM_BINS SHALL return 0.
REQ-028 rd_data SHALL reflect the new bank starting the cycle after swap_pulse.
REQ-029 frame_err_cnt SHALL saturate at 255.

Reset
REQ-030 On rst: state=IDLE, index=0, bank select=0, both banks=0, rd_data=0, swap_pulse=0, frame_err_cnt=0.
REQ-031 rst mid-COLLECT or mid-PENDING SHALL abandon the set without incrementing frame_err_cnt.
REQ-032 bin_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-033 Macro BIN_PEAK_HOLD_EN defined: the value written for bin i SHALL be max(clamped new, old - (old >>> DECAY_SHIFT)), where old is display-bank entry i read in the same cycle; compare is unsigned on clamped values.
REQ-034 BIN_PEAK_HOLD_EN undefined: the clamped new value SHALL be written directly, and no decay logic is synthesized.

Structure
REQ-035 Package vis_pkg SHALL hold NUM_BINS/BIN_W defaults and the FSM state enum typedef, shared with the VGA display logic.
REQ-036 Sub-module bin_bank SHALL implement the two-bank register file: one write port, one display read port, one peak-hold read port, and the bank select.

Verification
REQ-037 16 bins of value 100*i, bin_last on i=15, then vblank_start -> swap_pulse once; rd_addr=5 gives rd_data=500 next cycle.
REQ-038 bin_last at index 7 -> frame_err_cnt=1, bin_ready stays 1, and an rd_data sweep returns the prior set.
REQ-039 bin_data=16'h8000 at index 3 -> 0 stored at index 3 after swap.
REQ-040 Set complete, no vblank_start for 1000 cycles -> bin_ready=0 throughout, no swap; a later pulse swaps.
REQ-041 With BIN_PEAK_HOLD_EN, old bin 1600 and new bin 0 -> displayed value 1500, then 1407.
REQ-042 rst asserted after 9 bins -> frame_err_cnt=0, all rd_data=0, and a fresh 16-bin set is accepted normally.
